ram_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of the single-port 32x32 RAM (ports clk, ena, wena, addr, data_in, data_out).
- Two independent requesters (A, B) issue read or write requests.
- The block grants one request at a time, drives the RAM control pins for exactly one access cycle, and returns read data with a valid pulse.
- It is the only block allowed to drive the RAM.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 46 ++++
 rtl/ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants and state encoding for the RAM arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    // Requester indices, also used as bit positions in req/grant vectors
    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with a registered priority pointer.
// Latency: grant is combinational from req; the pointer updates on the clock edge when advance is high.
// Backpressure: none; the caller decides when a pick is consumed via advance.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Index of the requester that wins a tie
    logic ptr_q;
    logic ptr_d;

    // One-hot pick: a lone requester always wins, a tie goes to the pointer
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After any consumed grant the other requester gets priority
    always_comb begin
        ptr_d = ptr_q;
        if (advance && (grant != 2'b00)) begin
            ptr_d = grant[REQ_A];
        end
    end

    // Pointer register, A first out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'(REQ_A);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer owning the single-port RAM pins; optional RAM_INIT_EN zero-fills the RAM after reset.
// Latency: gnt one cycle after req is sampled in IDLE; write lands 1 cycle after gnt; read rvalid 3 cycles after gnt.
// Backpressure: requesters hold req/we/addr/wdata until their gnt pulse; one access in flight, no queueing.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    state_e            state_q;
    state_e            state_d;
    logic [1:0]        gnt_q;
    logic [1:0]        rvalid_q;
    logic              we_q;        // direction of the access in flight
    logic              owner_q;     // requester index owning the access in flight
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              ram_ena_q;
    logic              ram_wena_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              busy_q;
    logic [1:0]        pick;
    logic              arb_en;
`ifdef RAM_INIT_EN
    logic [ADDR_W-1:0] init_cnt_q;
    logic              init_last_q; // the top address has been issued
`endif

    // Next state; the gnt cycle itself is spent in IDLE with gnt_q set
    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef RAM_INIT_EN
            ST_INIT:   state_d = init_last_q ? ST_IDLE : ST_INIT;
`endif
            ST_IDLE:   state_d = (gnt_q != 2'b00) ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = we_q ? ST_IDLE : ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Arbitrate whenever the next cycle is IDLE, so a grant can show in that IDLE cycle
    assign arb_en = (state_d == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({b_req, a_req}),
        .advance (arb_en),
        .grant   (pick)
    );

    // State, grant, RAM drive and response registers; RAM pins follow state_d so they line up with state_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef RAM_INIT_EN
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_last_q <= 1'b0;
`else
            state_q     <= ST_IDLE;
`endif
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            ram_ena_q   <= 1'b0;
            ram_wena_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != ST_IDLE);
            ram_ena_q  <= (state_d != ST_IDLE);
            ram_wena_q <= (state_d == ST_INIT) || ((state_d == ST_ACCESS) && we_q);
            gnt_q      <= arb_en ? pick : 2'b00;

            // Latch the winner's command; later changes on its inputs are ignored
            if (arb_en && (pick != 2'b00)) begin
                owner_q     <= pick[REQ_B];
                we_q        <= pick[REQ_B] ? b_we    : a_we;
                ram_addr_q  <= pick[REQ_B] ? b_addr  : a_addr;
                ram_wdata_q <= pick[REQ_B] ? b_wdata : a_wdata;
            end

`ifdef RAM_INIT_EN
            // One zero write per cycle, counter wraps back to 0 after the top address
            if (state_d == ST_INIT) begin
                ram_addr_q  <= init_cnt_q;
                ram_wdata_q <= '0;
                init_cnt_q  <= init_cnt_q + 1'b1;
                init_last_q <= (init_cnt_q == {ADDR_W{1'b1}});
            end
`endif

            // Capture read data at the end of RESP and route it to the owner
            rvalid_q <= 2'b00;
            if (state_q == ST_RESP) begin
                if (owner_q) begin
                    b_rdata_q       <= ram_rdata;
                    rvalid_q[REQ_B] <= 1'b1;
                end else begin
                    a_rdata_q       <= ram_rdata;
                    rvalid_q[REQ_A] <= 1'b1;
                end
            end
        end
    end

    assign a_gnt     = gnt_q[REQ_A];
    assign b_gnt     = gnt_q[REQ_B];
    assign a_rvalid  = rvalid_q[REQ_A];
    assign b_rvalid  = rvalid_q[REQ_B];
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign ram_ena   = ram_ena_q;
    assign ram_wena  = ram_wena_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a combinational-read RAM model.
// Latency: checks gnt/access/rvalid cycle positions exactly.
// Backpressure: requesters hold their request until gnt, then drop it.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        ram_ena, ram_wena, busy;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [32];
    logic [31:0] exp_mem [32];
    logic        preload = 1'b0;
    int          n_chk = 0;
    int          n_bad = 0;

    ram_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, write on rising edge
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hDEAD_0000 | 32'(i);
        end else if (ram_ena && ram_wena) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit port, input bit val, input bit we, input logic [4:0] addr, input logic [31:0] wd);
        if (port) begin
            b_req = val; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = val; a_we = we; a_addr = addr; a_wdata = wd;
        end
    endtask

    task automatic wait_gnt(input bit port, output int lat);
        lat = 0;
        while (lat < 50) begin
            step();
            lat++;
            if (port ? b_gnt : a_gnt) break;
        end
    endtask

    // One complete access from an idle arbiter, checked cycle by cycle
    task automatic access(input bit port, input bit we, input logic [4:0] addr, input logic [31:0] wd);
        int lat;
        drive_req(port, 1'b1, we, addr, wd);
        wait_gnt(port, lat);
        chk("gnt_lat", 32'(lat), 32'd1);
        chk("gnt_other", 32'(port ? a_gnt : b_gnt), 32'd0);
        // garbage after grant must be ignored
        drive_req(port, 1'b0, ~we, ~addr, ~wd);
        step();
        chk("acc_ena", 32'(ram_ena), 32'd1);
        chk("acc_wena", 32'(ram_wena), 32'(we));
        chk("acc_addr", 32'(ram_addr), 32'(addr));
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_gnt_clr", 32'({a_gnt, b_gnt}), 32'd0);
        if (we) begin
            chk("acc_wdata", ram_wdata, wd);
            exp_mem[addr] = wd;
            step();
            chk("wr_done_ena", 32'(ram_ena), 32'd0);
            chk("wr_done_busy", 32'(busy), 32'd0);
        end else begin
            chk("acc_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
            step();
            chk("resp_ena", 32'(ram_ena), 32'd1);
            chk("resp_wena", 32'(ram_wena), 32'd0);
            chk("resp_addr", 32'(ram_addr), 32'(addr));
            chk("resp_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
            step();
            chk("rd_rvalid", 32'({a_rvalid, b_rvalid}), port ? 32'd1 : 32'd2);
            chk("rd_data", port ? b_rdata : a_rdata, exp_mem[addr]);
            chk("rd_busy", 32'(busy), 32'd0);
            step();
            chk("rd_rvalid_clr", 32'({a_rvalid, b_rvalid}), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_ctl", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_ena, ram_wena, busy}), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_rdata", a_rdata | b_rdata, 32'd0);
        rst_n = 1'b1;
`ifdef RAM_INIT_EN
        repeat (33) step();
        for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;
`else
        step();
        chk("post_rst_ena", 32'(ram_ena), 32'd0);
`endif
        chk("post_rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        drive_req(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) exp_mem[i] = 32'hDEAD_0000 | 32'(i);
        preload = 1'b1;
        step();
        preload = 1'b0;

`ifdef RAM_INIT_EN
        // Zero-fill after reset with a read of 17 pending from A throughout
        drive_req(1'b0, 1'b1, 1'b0, 5'd17, 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("init_ena", 32'({ram_ena, ram_wena, busy}), 32'd7);
            chk("init_addr", 32'(ram_addr), 32'(k - 1));
            chk("init_wdata", ram_wdata, 32'd0);
            chk("init_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        end
        step();
        chk("init_end_gnt", 32'(a_gnt), 32'd1);
        chk("init_end_busy", 32'(busy), 32'd0);
        a_req = 1'b0;
        step();
        step();
        step();
        chk("init_rvalid", 32'(a_rvalid), 32'd1);
        chk("init_rdata", a_rdata, 32'd0);
        step();
`endif

        do_reset();

        // Contention from reset: A first, then strict alternation while both hold writes
        drive_req(1'b0, 1'b1, 1'b1, 5'd10, 32'h1111_0000);
        drive_req(1'b1, 1'b1, 1'b1, 5'd11, 32'h2222_0000);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k % 2 == 1) chk("cont_gnt", 32'({b_gnt, a_gnt}), (((k - 1) / 2) % 2 == 0) ? 32'd1 : 32'd2);
            else            chk("cont_gnt", 32'({b_gnt, a_gnt}), 32'd0);
            if (k == 8) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
        end
        exp_mem[10] = 32'h1111_0000;
        exp_mem[11] = 32'h2222_0000;
        step();
        chk("cont_idle_ena", 32'(ram_ena), 32'd0);

        // Single write and read-back from A
        access(1'b0, 1'b1, 5'd3, 32'h0000_00AA);
        access(1'b0, 1'b0, 5'd3, 32'd0);
        access(1'b0, 1'b0, 5'd10, 32'd0);
        access(1'b0, 1'b0, 5'd3, 32'd0);

        // Fill and read back every address from B, ending with the 31 -> 0 wrap
        for (int i = 0; i < 32; i++) access(1'b1, 1'b1, 5'(i), 32'(i + 1));
        for (int i = 0; i < 32; i++) access(1'b1, 1'b0, 5'(i), 32'd0);
        access(1'b1, 1'b0, 5'd0, 32'd0);
        chk("a_rdata_hold", a_rdata, 32'h0000_00AA);
        chk("b_rdata_last", b_rdata, 32'd1);

        // Reset during RESP abandons the read
        drive_req(1'b0, 1'b1, 1'b0, 5'd5, 32'd0);
        wait_gnt(1'b0, lat);
        chk("mr_gnt_lat", 32'(lat), 32'd1);
        a_req = 1'b0;
        step();
        step();
        chk("mr_resp_ena", 32'(ram_ena), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mr_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        chk("mr_ctl", 32'({ram_ena, ram_wena, busy, a_gnt, b_gnt}), 32'd0);
        chk("mr_rdata", a_rdata, 32'd0);
        do_reset();
        access(1'b0, 1'b0, 5'd5, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

endmodule
